sms_sample_pulse_gen: RTL

Parametrised, multi-channel successor to the single-channel SDTRL sample-pulse one-shot. Each channel watches a gated trigger. It emits a clean, synchronous sample pulse whose width is set at run time, then optionally enforces a holdoff window. Supports a retrigger (pulse-extend) mode and flags triggers that are lost. It sits between the SMS-card timing logic and the sampling latches that consume the pulses.

---
 rtl/sms_sample_pulse_gen_if.sv | 25 ++
 rtl/sms_sample_pulse_gen.sv | 130 +++++++++++++
 2 files changed

// File: rtl/sms_sample_pulse_gen_if.sv
// Control/status bundle for the multi-channel sample-pulse generator.
// The master side (timing logic) drives triggers, gates, width and clear;
// the slave side (the generator) returns pulse, busy and overrun per channel.
interface sms_sample_pulse_gen_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 4
);
  logic [CHANNELS-1:0] trig;
  logic [CHANNELS-1:0] gate;
  logic [CNT_W-1:0]    width;
  logic                clr;
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] busy;
  logic [CHANNELS-1:0] overrun;

  modport master (
    output trig, gate, width, clr,
    input  pulse, busy, overrun
  );

  modport slave (
    input  trig, gate, width, clr,
    output pulse, busy, overrun
  );
endinterface

// File: rtl/sms_sample_pulse_gen.sv
// Multi-channel sample-pulse one-shot. Each channel turns a gated rising
// trigger edge into a registered pulse of run-time width, optionally followed
// by a holdoff window, with optional pulse extension on retrigger and a sticky
// flag for triggers that could not be serviced.
module sms_sample_pulse_gen #(
  parameter int CHANNELS       = 4,
  parameter int CNT_W          = 4,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int RETRIGGER      = 0
) (
  input  logic                 x,
  input  logic                 rst,
  sms_sample_pulse_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam bit RETRIG_EN = (RETRIGGER != 0);
  localparam bit HOLD_EN   = (HOLDOFF_CYCLES != 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD =
    HOLD_EN ? CNT_W'(HOLDOFF_CYCLES - 1) : '0;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] trig_q;
  logic [CHANNELS-1:0] qe;
  logic [CHANNELS-1:0] ov_set;
  logic [CHANNELS-1:0] pulse_q, pulse_d;
  logic [CHANNELS-1:0] busy_q,  busy_d;
  logic [CHANNELS-1:0] ov_q,    ov_d;
  logic [CNT_W-1:0]    width_load;

  // A programmed width of 0 behaves as 1, so the load value is max(width,1)-1.
  assign width_load = (bus.width == '0) ? '0 : bus.width - CNT_W'(1);

  // Qualifying event: rising trigger edge with the gate open in the same cycle.
  assign qe = bus.trig & ~trig_q & bus.gate;

  // Per-channel next-state, counter, pulse/busy and overrun-set decode.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    ov_set  = '0;
    pulse_d = '0;
    busy_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        IDLE: begin
          if (qe[c]) begin
            state_d[c] = ACTIVE;
            cnt_d[c]   = width_load;
          end
        end
        ACTIVE: begin
          if (RETRIG_EN && qe[c]) begin
            // Reload wins over expiry, even on the last pulse cycle.
            cnt_d[c] = width_load;
          end else begin
            ov_set[c] = qe[c];
            if (cnt_q[c] == '0) begin
              if (HOLD_EN) begin
                state_d[c] = HOLDOFF;
                cnt_d[c]   = HOLD_LOAD;
              end else begin
                state_d[c] = IDLE;
              end
            end else begin
              cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end
          end
        end
        HOLDOFF: begin
          ov_set[c] = qe[c];
          if (cnt_q[c] == '0) begin
            state_d[c] = IDLE;
          end else begin
            cnt_d[c] = cnt_q[c] - CNT_W'(1);
          end
        end
        default: begin
          state_d[c] = IDLE;
          cnt_d[c]   = '0;
        end
      endcase
      pulse_d[c] = (state_d[c] == ACTIVE);
      busy_d[c]  = (state_d[c] != IDLE);
    end
    // A new overrun in the same cycle as a clear keeps the flag set.
    ov_d = ov_set | (ov_q & ~{CHANNELS{bus.clr}});
  end

  // State, counters, trigger history and registered outputs.
  always_ff @(posedge x or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
      end
      // History resets high so a trigger already asserted at release is not an edge.
      trig_q  <= '1;
      pulse_q <= '0;
      busy_q  <= '0;
      ov_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      trig_q  <= bus.trig;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.pulse   = pulse_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = ov_q;

endmodule
